pipelined_select_adder: RTL and testbench



---
 rtl/pipelined_select_adder.sv | 197 +++++++++++++++++++
 tb/tb_pipelined_select_adder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder: WIDTH-bit A+B+cin, one carry-select block of BLK_W bits per stage.
// Latency NUM_BLK cycles (WIDTH/BLK_W) from accept to out_valid; throughput one beat per cycle.
// Backpressure: out_ready low holds the last stage, bubbles collapse upstream, in_ready drops when full.
//
// Optional feature macro: SELECT_ADD_SUB_EN (adds the 'sub' input; sum = A-B when sub=1).
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (a, b, cin [, sub])
//   out_valid / out_ready result beat handshake (sum, cout, ovf)
//   op_count              number of results handed off, wraps at 2^CNT_W
module pipelined_select_adder #(
   parameter int WIDTH = 16,
   parameter int BLK_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SELECT_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [CNT_W-1:0] op_count
);

   localparam int NUM_BLK = WIDTH / BLK_W;

   // Elaboration-time guard: the operand must split evenly into blocks.
   generate
      if ((BLK_W < 1) || ((WIDTH % BLK_W) != 0)) begin : g_bad_width
         $error("pipelined_select_adder: WIDTH must be a positive multiple of BLK_W");
      end
   endgenerate

   // Ripple add of one block for a fixed carry-in; returns {carry_out, sum}.
   function automatic logic [BLK_W:0] f_ripple(
      input logic [BLK_W-1:0] x,
      input logic [BLK_W-1:0] y,
      input logic             c_in
   );
      logic [BLK_W-1:0] s;
      logic             c;
      c = c_in;
      s = '0;
      for (int i = 0; i < BLK_W; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   // Effective operands entering stage 0. In subtract mode B is inverted
   // and the carry-in forced to 1 (two's-complement negate).
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;

`ifdef SELECT_ADD_SUB_EN
   assign w_b_eff   = sub ? ~b : b;
   assign w_cin_eff = sub ? 1'b1 : cin;
`else
   assign w_b_eff   = b;
   assign w_cin_eff = cin;
`endif

   // Per-stage valid bits and load enables.
   logic [NUM_BLK-1:0] w_vld;
   logic [NUM_BLK-1:0] w_load;

   // Stage k loads when it is empty or its successor moves. Evaluated
   // from the output end back so a free slot anywhere lets upstream move.
   always_comb begin
      w_load = '0;
      w_load[NUM_BLK-1] = !w_vld[NUM_BLK-1] || out_ready;
      for (int k = NUM_BLK - 2; k >= 0; k--) begin
         w_load[k] = !w_vld[k] || w_load[k+1];
      end
   end

   assign in_ready = w_load[0];

   generate
      for (genvar k = 0; k < NUM_BLK; k++) begin : g_stage
         localparam int LO  = BLK_W * k;      // result bits already computed upstream
         localparam int REM = WIDTH - LO;     // operand bits still to be added

         logic [REM-1:0]      w_a_src;
         logic [REM-1:0]      w_b_src;
         logic                w_c_src;
         logic                w_v_src;
         logic [BLK_W:0]      w_r0;
         logic [BLK_W:0]      w_r1;
         logic [BLK_W:0]      w_sel;
         logic [LO+BLK_W-1:0] w_sum_nxt;

         logic                r_vld;
         logic [LO+BLK_W-1:0] r_sum;
         logic                r_carry;

         if (k == 0) begin : g_src
            assign w_a_src   = a;
            assign w_b_src   = w_b_eff;
            assign w_c_src   = w_cin_eff;
            assign w_v_src   = in_valid;
            assign w_sum_nxt = w_sel[BLK_W-1:0];
         end else begin : g_src
            assign w_a_src   = g_stage[k-1].g_rem.r_a_rem;
            assign w_b_src   = g_stage[k-1].g_rem.r_b_rem;
            assign w_c_src   = g_stage[k-1].r_carry;
            assign w_v_src   = g_stage[k-1].r_vld;
            assign w_sum_nxt = {w_sel[BLK_W-1:0], g_stage[k-1].r_sum};
         end

         // Both carry hypotheses are resolved in parallel; the incoming
         // carry only drives the final select.
         assign w_r0  = f_ripple(w_a_src[BLK_W-1:0], w_b_src[BLK_W-1:0], 1'b0);
         assign w_r1  = f_ripple(w_a_src[BLK_W-1:0], w_b_src[BLK_W-1:0], 1'b1);
         assign w_sel = w_c_src ? w_r1 : w_r0;

         assign w_vld[k] = r_vld;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
            end else if (w_load[k]) begin
               r_vld <= w_v_src;
            end
         end

         // Payload only moves with a valid beat, so a held result stays put.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sum   <= '0;
               r_carry <= 1'b0;
            end else if (w_load[k] && w_v_src) begin
               r_sum   <= w_sum_nxt;
               r_carry <= w_sel[BLK_W];
            end
         end

         if (k < NUM_BLK - 1) begin : g_rem
            // Upper operand bits ride along, skewed one block per stage.
            logic [REM-BLK_W-1:0] r_a_rem;
            logic [REM-BLK_W-1:0] r_b_rem;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_a_rem <= '0;
                  r_b_rem <= '0;
               end else if (w_load[k] && w_v_src) begin
                  r_a_rem <= w_a_src[REM-1:BLK_W];
                  r_b_rem <= w_b_src[REM-1:BLK_W];
               end
            end
         end else begin : g_msb
            // Carry into the MSB recovered from the MSB sum bit:
            // s = a ^ b ^ c  =>  c = a ^ b ^ s.
            logic r_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_cmsb <= 1'b0;
               end else if (w_load[k] && w_v_src) begin
                  r_cmsb <= w_a_src[REM-1] ^ w_b_src[REM-1] ^ w_sel[BLK_W-1];
               end
            end
         end
      end
   endgenerate

   assign out_valid = w_vld[NUM_BLK-1];
   assign sum       = g_stage[NUM_BLK-1].r_sum;
   assign cout      = g_stage[NUM_BLK-1].r_carry;
   assign ovf       = g_stage[NUM_BLK-1].g_msb.r_cmsb ^ g_stage[NUM_BLK-1].r_carry;

   // Completed-operation counter; wraps naturally at 2^CNT_W.
   logic [CNT_W-1:0] r_op_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (out_valid && out_ready) begin
         r_op_count <= r_op_count + 1'b1;
      end
   end

   assign op_count = r_op_count;

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Directed bench for pipelined_select_adder at default parameters (16-bit, 4-bit blocks).
// Table of single-beat vectors with exact latency check, then streaming, fill and reset sequences.
// Expected results come from hand-computed constants and a plain arithmetic reference model.
module tb_pipelined_select_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic [15:0] op_count;

   pipelined_select_adder #(.WIDTH(16), .BLK_W(4), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SELECT_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference: returns {ovf, cout, sum}.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
      logic [16:0] r;
      logic [15:0] yy;
      logic        cc;
      yy = s ? ~y : y;
      cc = s ? 1'b1 : c;
      r  = {1'b0, x} + {1'b0, yy} + {16'b0, cc};
      return {(x[15] == yy[15]) && (r[15] != x[15]), r};
   endfunction

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic        vcin;
      logic        vsub;
      logic [15:0] esum;
      logic        ecout;
      logic        eovf;
   } vec_t;

`ifdef SELECT_ADD_SUB_EN
   localparam int NV = 10;
`else
   localparam int NV = 8;
`endif

   vec_t        vec[NV];
   logic [15:0] sa[20];
   logic [15:0] sb[20];
   logic        sc[20];
   logic        ss[20];
   logic [17:0] q[$];

   initial begin
      int nsent, nrecv, cyc, n_unexp, nacc, nvis;
      logic stall_prev;
      logic [17:0] held;

      vec[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vec[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vec[2] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
      vec[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vec[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vec[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vec[6] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      vec[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
`ifdef SELECT_ADD_SUB_EN
      vec[8] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vec[9] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`endif

      for (int i = 0; i < 20; i++) begin
         sa[i] = 16'($urandom);
         sb[i] = 16'($urandom);
         sc[i] = 1'($urandom_range(0, 1));
`ifdef SELECT_ADD_SUB_EN
         ss[i] = 1'($urandom_range(0, 1));
`else
         ss[i] = 1'b0;
`endif
      end

      // Reset then idle
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_op_count", op_count, 0);
      check("reset_sum", {ovf, cout, sum}, 0);

      // Single-beat vectors with exact latency
      for (int i = 0; i < NV; i++) begin
         a = vec[i].va; b = vec[i].vb; cin = vec[i].vcin; sub = vec[i].vsub;
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         check($sformatf("vec%0d_not_early", i), out_valid, 0);
         @(posedge clk); #1;
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_sum", i), sum, vec[i].esum);
         check($sformatf("vec%0d_cout_ovf", i), {cout, ovf}, {vec[i].ecout, vec[i].eovf});
         @(posedge clk); #1;
         check($sformatf("vec%0d_op_count", i), op_count, i + 1);
         check($sformatf("vec%0d_drained", i), out_valid, 0);
      end

      // Fresh reset before streaming so op_count restarts
      rst_n = 1'b0; #2; rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst2_op_count", op_count, 0);

      // Streaming, out_ready pattern 1,0,0,1
      nsent = 0; nrecv = 0; cyc = 0; n_unexp = 0; stall_prev = 1'b0; held = '0;
      q.delete();
      while (nrecv < 20 && cyc < 400) begin
         out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         if (nsent < 20) begin
            in_valid = 1'b1; a = sa[nsent]; b = sb[nsent]; cin = sc[nsent]; sub = ss[nsent];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (stall_prev) check("stream_stall_hold", {out_valid, ovf, cout, sum}, {1'b1, held});
         stall_prev = out_valid && !out_ready;
         held = {ovf, cout, sum};
         if (out_valid && out_ready) begin
            if (q.size() == 0) n_unexp++;
            else check($sformatf("stream_res%0d", nrecv), {ovf, cout, sum}, q.pop_front());
            nrecv++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            nsent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream_recv_count", nrecv, 20);
      check("stream_no_unexpected", n_unexp, 0);
      check("stream_queue_empty", q.size(), 0);
      check("stream_op_count", op_count, 20);
      repeat (3) @(posedge clk);
      #1;
      check("stream_no_extra", out_valid, 0);

      // Fill with out_ready held low: in_ready must fall after 4 accepts
      out_ready = 1'b0; nacc = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; a = 16'h1111 * 16'(i + 1); b = 16'h0F0F; cin = 1'(i); sub = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            nacc++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("fill_accepts", nacc, 4);
      check("fill_in_ready_low", in_ready, 0);
      out_ready = 1'b1; nrecv = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (q.size() != 0) check($sformatf("fill_res%0d", nrecv), {ovf, cout, sum}, q.pop_front());
            nrecv++;
         end
         @(posedge clk); #1;
      end
      check("fill_drain_count", nrecv, 4);
      check("fill_op_count", op_count, 24);

      // Reset mid-stream with 3 beats in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 16'h0100 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("midrst_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid_now", out_valid, 0);
      check("midrst_op_count", op_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      nvis = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) nvis++;
         @(posedge clk); #1;
      end
      check("midrst_no_stale", nvis, 0);
      check("midrst_op_count_after", op_count, 0);
      check("midrst_in_ready", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
